// File: rtl/multi_byte_add_seq.sv
// Byte-serial multi-precision adder: streams NBYTES byte pairs through one
// 8-bit ripple adder, one byte per clock, with a start/done handshake.

module Full_Adder_by8 (
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       Cin,
    output logic [7:0] S,
    output logic       Cout
);
    logic [8:0] c;

    assign c[0] = Cin;

    for (genvar i = 0; i < 8; i++) begin : g_bit
        assign S[i]   = A[i] ^ B[i] ^ c[i];
        assign c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
    end

    assign Cout = c[8];
endmodule

// state | meaning
// IDLE  | waiting for start; result registers hold
// ADD   | one byte of the operands summed per cycle, LSB first
// DONE  | one-cycle done pulse, then back to IDLE
module multi_byte_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8*NBYTES-1:0] op_a,
    input  logic [8*NBYTES-1:0] op_b,
    input  logic                cin,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout,
    output logic                ovf
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

    state_t        state;
    state_t        next_state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic          carry;
    logic [IW-1:0] idx;
    logic [7:0]    add_a;
    logic [7:0]    add_b;
    logic [7:0]    add_s;
    logic          add_c;

    assign add_a = a_reg[8*idx +: 8];
    assign add_b = b_reg[8*idx +: 8];

    Full_Adder_by8 u_add (
        .A    (add_a),
        .B    (add_b),
        .Cin  (carry),
        .S    (add_s),
        .Cout (add_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = ADD;
            ADD:     if (idx == LAST) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == ADD);
        done = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= op_a;
                        b_reg <= op_b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                ADD: begin
                    sum[8*idx +: 8] <= add_s;
                    carry           <= add_c;
                    if (idx == LAST) begin
                        // top byte: carry leaves via cout only, never wraps to byte 0
                        idx  <= '0;
                        cout <= add_c;
                        ovf  <= (a_reg[W-1] == b_reg[W-1]) && (add_s[7] != a_reg[W-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
